// File: rtl/ltc_2656_sequencer.sv
// ltc_2656_sequencer: shadow-register file that flushes dirty channels to the ltc_2656 SPI driver
// in ascending channel order, optionally finishing with one simultaneous LDAC update.
module ltc_2656_sequencer #(
  parameter bit LDAC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [2:0]  wr_channel,
  input  logic [15:0] wr_value,
  input  logic        commit,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dirty,
  input  logic        drv_idle,
  output logic        drv_start,
  output logic [3:0]  drv_cmd,
  output logic [3:0]  drv_channel,
  output logic [15:0] drv_value,
  output logic        drv_ldac
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LDAC  = 3'd4;
  localparam logic [2:0] S_LHOLD = 3'd5;
  localparam logic [2:0] S_LWAIT = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  logic [2:0]  r_state;
  logic [15:0] r_shadow [8];
  logic [7:0]  r_pending;
  logic        r_commit_q;
  logic [2:0]  w_n;
  logic [7:0]  w_set;
  logic [7:0]  w_clr;
  logic [7:0]  w_mask;
  logic        w_issue;
  always_comb begin
    w_n = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (r_pending[i]) w_n = 3'(i);
  end
  assign w_issue = (r_state == S_ISSUE) && drv_idle;
  assign w_set   = wr_en ? (8'b1 << wr_channel) : 8'b0;
  assign w_clr   = w_issue ? (8'b1 << w_n) : 8'b0;
  // a write landing in the commit cycle joins the flush
  assign w_mask  = dirty | w_set;
  assign busy    = (r_state != S_IDLE) || r_commit_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_pending   <= 8'b0;
      r_commit_q  <= 1'b0;
      dirty       <= 8'b0;
      done        <= 1'b0;
      drv_start   <= 1'b0;
      drv_ldac    <= 1'b0;
      drv_cmd     <= 4'b0;
      drv_channel <= 4'b0;
      drv_value   <= 16'b0;
      for (int i = 0; i < 8; i++) r_shadow[i] <= 16'h0000;
    end else begin
      // a same-cycle write re-sets the bit being cleared by the issue
      dirty     <= (dirty & ~w_clr) | w_set;
      r_pending <= r_pending & ~w_clr;
      done      <= 1'b0;
      if (wr_en) r_shadow[wr_channel] <= wr_value;
      if (commit && r_state != S_IDLE) r_commit_q <= 1'b1;
      case (r_state)
        S_IDLE: if (commit || r_commit_q) begin
          r_commit_q <= 1'b0;
          r_pending  <= w_mask;
          r_state    <= (w_mask == 8'b0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (drv_idle) begin
          drv_cmd     <= LDAC_EN ? 4'b0000 : 4'b0011;
          drv_channel <= {1'b0, w_n};
          drv_value   <= r_shadow[w_n];
          drv_start   <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          drv_start <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (drv_idle)
          r_state <= (r_pending != 8'b0) ? S_ISSUE : (LDAC_EN ? S_LDAC : S_DONE);
        S_LDAC: begin
          drv_ldac <= 1'b1;
          r_state  <= S_LHOLD;
        end
        S_LHOLD: begin
          drv_ldac <= 1'b0;
          r_state  <= S_LWAIT;
        end
        S_LWAIT: if (drv_idle) r_state <= S_DONE;
        default: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ltc_2656_sequencer.sv
// tb_ltc_2656_sequencer: directed bench with a transfer scoreboard and simple driver models,
// one sequencer built with LDAC_EN=1 and one with LDAC_EN=0.
module tb_ltc_2656_sequencer;
  logic        clk, resetn;
  logic        wr_en_a, wr_en_b, commit_a, commit_b;
  logic [2:0]  wr_channel;
  logic [15:0] wr_value;
  logic        busy_a, done_a, idle_a, start_a, ldac_a;
  logic        busy_b, done_b, idle_b, start_b, ldac_b;
  logic [7:0]  dirty_a, dirty_b;
  logic [3:0]  cmd_a, ch_a, cmd_b, ch_b;
  logic [15:0] val_a, val_b;
  logic [6:0]  cnt_a, cnt_b;
  logic        prev_a, prev_b;
  logic [23:0] exp_a [$];
  logic [23:0] exp_b [$];
  int n_cmp = 0, n_err = 0;
  int sc_a = 0, lc_a = 0, dc_a = 0, sc_b = 0, lc_b = 0, dc_b = 0;

  ltc_2656_sequencer #(.LDAC_EN(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .wr_en(wr_en_a), .wr_channel(wr_channel), .wr_value(wr_value),
    .commit(commit_a), .busy(busy_a), .done(done_a), .dirty(dirty_a), .drv_idle(idle_a),
    .drv_start(start_a), .drv_cmd(cmd_a), .drv_channel(ch_a), .drv_value(val_a), .drv_ldac(ldac_a));
  ltc_2656_sequencer #(.LDAC_EN(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .wr_en(wr_en_b), .wr_channel(wr_channel), .wr_value(wr_value),
    .commit(commit_b), .busy(busy_b), .done(done_b), .dirty(dirty_b), .drv_idle(idle_b),
    .drv_start(start_b), .drv_cmd(cmd_b), .drv_channel(ch_b), .drv_value(val_b), .drv_ldac(ldac_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver models: idle drops with start, stays low 60 cycles per transfer and 3 per LDAC
  assign idle_a = (cnt_a == 7'd0) && !start_a;
  assign idle_b = (cnt_b == 7'd0) && !start_b;
  always @(posedge clk or negedge resetn)
    if (!resetn) cnt_a <= 7'd0;
    else if (start_a) cnt_a <= 7'd60;
    else if (ldac_a) cnt_a <= 7'd3;
    else if (cnt_a != 7'd0) cnt_a <= cnt_a - 7'd1;
  always @(posedge clk or negedge resetn)
    if (!resetn) cnt_b <= 7'd0;
    else if (start_b) cnt_b <= 7'd60;
    else if (ldac_b) cnt_b <= 7'd3;
    else if (cnt_b != 7'd0) cnt_b <= cnt_b - 7'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_a) chk("start_a_width", start_a, 1'b0);
    if (prev_b) chk("start_b_width", start_b, 1'b0);
    prev_a <= start_a;
    prev_b <= start_b;
    if (start_a) begin
      sc_a++;
      if (exp_a.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL xfer_a_unexpected: observed %h expected none", {cmd_a, ch_a, val_a});
      end else chk("xfer_a", {cmd_a, ch_a, val_a}, exp_a.pop_front());
    end
    if (start_b) begin
      sc_b++;
      if (exp_b.size() == 0) begin
        n_cmp++; n_err++;
        $error("FAIL xfer_b_unexpected: observed %h expected none", {cmd_b, ch_b, val_b});
      end else chk("xfer_b", {cmd_b, ch_b, val_b}, exp_b.pop_front());
    end
    if (ldac_a) lc_a++;
    if (ldac_b) lc_b++;
    if (done_a) dc_a++;
    if (done_b) dc_b++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input bit b, input logic [2:0] ch, input logic [15:0] v);
    wr_channel = ch;
    wr_value = v;
    if (b) wr_en_b = 1'b1; else wr_en_a = 1'b1;
    step();
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic pulse_commit(input bit b);
    if (b) commit_b = 1'b1; else commit_a = 1'b1;
    step();
    commit_a = 1'b0;
    commit_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    while (!found && cyc < 1000) begin
      step();
      cyc++;
      found = b ? done_b : done_a;
    end
    chk(b ? "done_b_timeout" : "done_a_timeout", found, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s0, l0, d0;
    resetn = 1'b0;
    wr_en_a = 1'b0; wr_en_b = 1'b0; commit_a = 1'b0; commit_b = 1'b0;
    wr_channel = 3'd0; wr_value = 16'h0;
    repeat (3) step();
    chk("reset_a", {busy_a, done_a, start_a, ldac_a, dirty_a, cmd_a, ch_a, val_a}, 64'h0);
    chk("reset_b", {busy_b, done_b, start_b, ldac_b, dirty_b, cmd_b, ch_b, val_b}, 64'h0);
    resetn = 1'b1;
    step();

    // basic flush with LDAC
    wr(1'b0, 3'd2, 16'h1234);
    wr(1'b0, 3'd5, 16'hABCD);
    chk("dirty_after_writes", dirty_a, 8'h24);
    exp_a.push_back({4'h0, 4'h2, 16'h1234});
    exp_a.push_back({4'h0, 4'h5, 16'hABCD});
    s0 = sc_a; l0 = lc_a;
    pulse_commit(1'b0);
    chk("start_low_after_edge0", start_a, 1'b0);
    chk("busy_after_commit", busy_a, 1'b1);
    step();
    chk("start_high_after_edge1", start_a, 1'b1);
    wait_done(1'b0, cyc);
    chk("basic_starts", sc_a - s0, 2);
    chk("basic_ldacs", lc_a - l0, 1);
    chk("basic_dirty", dirty_a, 8'h00);
    chk("basic_busy_with_done", busy_a, 1'b0);

    // empty commit
    step();
    s0 = sc_a; l0 = lc_a; d0 = dc_a;
    pulse_commit(1'b0);
    chk("empty_busy", busy_a, 1'b1);
    chk("empty_done_early", done_a, 1'b0);
    step();
    chk("empty_done", done_a, 1'b1);
    chk("empty_busy_fall", busy_a, 1'b0);
    repeat (5) step();
    chk("empty_starts", sc_a - s0, 0);
    chk("empty_ldacs", lc_a - l0, 0);
    chk("empty_dones", dc_a - d0, 1);

    // writes during a flush plus two queued commits
    wr(1'b0, 3'd2, 16'h1111);
    wr(1'b0, 3'd5, 16'h2222);
    exp_a.push_back({4'h0, 4'h2, 16'h1111});
    exp_a.push_back({4'h0, 4'h5, 16'h5555});
    exp_a.push_back({4'h0, 4'h2, 16'h0F0F});
    s0 = sc_a; l0 = lc_a; d0 = dc_a;
    pulse_commit(1'b0);
    repeat (5) step();
    wr(1'b0, 3'd5, 16'h5555);
    wr(1'b0, 3'd2, 16'h0F0F);
    pulse_commit(1'b0);
    repeat (3) step();
    pulse_commit(1'b0);
    wait_done(1'b0, cyc);
    chk("wdf_dirty", dirty_a, 8'h04);
    chk("wdf_busy_queued", busy_a, 1'b1);
    chk("wdf_starts", sc_a - s0, 2);
    wait_done(1'b0, cyc);
    chk("queued_dirty", dirty_a, 8'h00);
    chk("queued_starts", sc_a - s0, 3);
    chk("queued_ldacs", lc_a - l0, 2);
    repeat (150) step();
    chk("queued_dones", dc_a - d0, 2);
    chk("queued_idle", busy_a, 1'b0);

    // write-and-update mode, no LDAC
    wr(1'b1, 3'd7, 16'hFFFF);
    exp_b.push_back({4'h3, 4'h7, 16'hFFFF});
    pulse_commit(1'b1);
    wait_done(1'b1, cyc);
    chk("b_done_after_idle", cyc >= 60, 1'b1);
    chk("b_starts", sc_b, 1);
    chk("b_ldacs", lc_b, 0);
    chk("b_dirty", dirty_b, 8'h00);

    // asynchronous reset in the middle of a flush
    wr(1'b0, 3'd3, 16'h3333);
    exp_a.push_back({4'h0, 4'h3, 16'h3333});
    pulse_commit(1'b0);
    repeat (10) step();
    d0 = dc_a;
    chk("midflush_busy", busy_a, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_a", {busy_a, done_a, start_a, ldac_a, dirty_a, cmd_a, ch_a, val_a}, 64'h0);
    chk("async_reset_b", {busy_b, done_b, start_b, ldac_b, dirty_b, cmd_b, ch_b, val_b}, 64'h0);
    step();
    resetn = 1'b1;
    repeat (80) step();
    chk("post_reset_dirty", dirty_a, 8'h00);
    chk("post_reset_no_done", dc_a - d0, 0);
    chk("post_reset_busy", busy_a, 1'b0);
    chk("scoreboard_a_empty", exp_a.size(), 0);
    chk("scoreboard_b_empty", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
